hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 94 +++++++++
 rtl/hazard_ctrl_md_timer.sv | 46 ++++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the pipeline hazard controller.
//   - md_state_e   : multiply/divide sequencer state (RUN, BUSY)
//   - hz_cause_e   : the single winning hazard cause for a cycle
//   - pipe_ctrl_t  : bundle of per-register stall/flush controls
//   - DEF_MUL_LAT / DEF_DIV_LAT : default multiply/divide latencies
//   - cnt_width()  : countdown width for the larger of two latencies
//   - ctrl_for_cause() : stall/flush pattern for one hazard cause
package hazard_pkg;

  localparam int DEF_MUL_LAT = 3;
  localparam int DEF_DIV_LAT = 34;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Listed in decreasing priority after CAUSE_NONE.
  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_RESET    = 3'd1,
    CAUSE_TRAP     = 3'd2,
    CAUSE_MEM      = 3'd3,
    CAUSE_MD       = 3'd4,
    CAUSE_LOAD_USE = 3'd5,
    CAUSE_REDIRECT = 3'd6,
    CAUSE_FETCH    = 3'd7
  } hz_cause_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic stall_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } pipe_ctrl_t;

  // ceil(log2(max(a, b))), never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  // Each cause holds the registers upstream of the blocked stage and
  // inserts a bubble into the first register downstream of it, so no
  // register is ever both held and cleared. Only reset/trap clear all.
  function automatic pipe_ctrl_t ctrl_for_cause(input hz_cause_e c);
    pipe_ctrl_t p;
    p = '0;
    case (c)
      CAUSE_RESET, CAUSE_TRAP: begin
        p.flush_if_id  = 1'b1;
        p.flush_id_ex  = 1'b1;
        p.flush_ex_mem = 1'b1;
        p.flush_mem_wb = 1'b1;
      end
      CAUSE_MEM: begin
        p.stall_pc     = 1'b1;
        p.stall_if_id  = 1'b1;
        p.stall_id_ex  = 1'b1;
        p.stall_ex_mem = 1'b1;
        p.flush_mem_wb = 1'b1;
      end
      CAUSE_MD: begin
        p.stall_pc     = 1'b1;
        p.stall_if_id  = 1'b1;
        p.stall_id_ex  = 1'b1;
        p.flush_ex_mem = 1'b1;
      end
      CAUSE_LOAD_USE: begin
        p.stall_pc     = 1'b1;
        p.stall_if_id  = 1'b1;
        p.flush_id_ex  = 1'b1;
      end
      CAUSE_REDIRECT: begin
        p.flush_if_id  = 1'b1;
        p.flush_id_ex  = 1'b1;
      end
      CAUSE_FETCH: begin
        p.stall_pc     = 1'b1;
        p.flush_if_id  = 1'b1;
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// md_timer
//   Countdown for an in-flight multiply/divide. On load the counter is set
//   to (latency - 1) for the selected operation, then counts down by one
//   per enabled cycle and sticks at zero.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset, clears the counter
//   clear  : synchronous abort (trap), clears the counter
//   load   : start a new operation this edge
//   is_div : latency select for load (1 = divide, 0 = multiply)
//   en     : count down this edge
//   zero   : counter currently equals zero
module md_timer
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CW      = cnt_width(MUL_LAT, DIV_LAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic is_div,
  input  logic en,
  output logic zero
);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= is_div ? DIV_LOAD : MUL_LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline stall/flush controller for a 5-stage pipe plus a multicycle
//   multiply/divide sequencer. Exactly one hazard cause wins per cycle, in
//   the order: reset, wb_trap, mem_busy, mul/div busy, load-use,
//   ex_redirect, if_busy. All stall/flush outputs are combinational.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   if_busy                  : fetch not ready
//   mem_busy                 : MEM data access not complete
//   id_rs1/id_rs2            : ID source registers
//   id_use_rs1/id_use_rs2    : ID actually reads that source
//   ex_rd, ex_is_load        : EX destination / EX holds a load
//   ex_md_start, ex_md_is_div: EX holds mul/div (level) / it is a divide
//   ex_redirect              : EX branch/jump mispredict
//   wb_trap                  : trap/xRET redirect at WB
//   stall_*                  : hold the named pipeline register
//   flush_*                  : clear the named pipeline register to a bubble
//   md_done                  : mul/div result valid this cycle
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_busy,
  input  logic       mem_busy,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_md_start,
  input  logic       ex_md_is_div,
  input  logic       ex_redirect,
  input  logic       wb_trap,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       stall_ex_mem,
  output logic       stall_mem_wb,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       flush_mem_wb,
  output logic       md_done
);

  localparam int CW = cnt_width(MUL_LAT, DIV_LAT);

  md_state_e  state_q;
  md_state_e  state_d;
  logic       timer_load;
  logic       cnt_zero;
  logic       md_busy;
  logic       load_use;
  hz_cause_e  cause;
  pipe_ctrl_t ctrl;

  // ---------------------------------------------------------------------
  // Mul/div sequencer: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Mul/div sequencer: next state
  // A start is only accepted when MEM is not stalling the pipe; while BUSY
  // the level-held ex_md_start of the same instruction is ignored. The
  // done state is held while mem_busy keeps the result parked in EX.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    if (wb_trap) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_md_start && !mem_busy) begin
            state_d    = ST_BUSY;
            timer_load = 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt_zero && !mem_busy) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  md_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CW      (CW)
  ) u_md_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (wb_trap),
    .load   (timer_load),
    .is_div (ex_md_is_div),
    .en     (state_q == ST_BUSY),
    .zero   (cnt_zero)
  );

  // The first cycle of an operation (still in RUN) already stalls, so a
  // latency of N gives exactly N stall cycles before md_done.
  assign md_busy = ((state_q == ST_RUN)  && ex_md_start) ||
                   ((state_q == ST_BUSY) && !cnt_zero);

  assign md_done = !rst && !wb_trap && (state_q == ST_BUSY) && cnt_zero;

  // x0 is never a real dependency.
  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // ---------------------------------------------------------------------
  // Hazard arbitration. ex_redirect sits below every cause that holds EX,
  // so a mispredict is only acted on once its branch actually leaves EX.
  // ---------------------------------------------------------------------
  always_comb begin
    cause = CAUSE_NONE;
    if (rst) begin
      cause = CAUSE_RESET;
    end else if (wb_trap) begin
      cause = CAUSE_TRAP;
    end else if (mem_busy) begin
      cause = CAUSE_MEM;
    end else if (md_busy) begin
      cause = CAUSE_MD;
    end else if (load_use) begin
      cause = CAUSE_LOAD_USE;
    end else if (ex_redirect) begin
      cause = CAUSE_REDIRECT;
    end else if (if_busy) begin
      cause = CAUSE_FETCH;
    end
  end

  assign ctrl = ctrl_for_cause(cause);

  assign stall_pc     = ctrl.stall_pc;
  assign stall_if_id  = ctrl.stall_if_id;
  assign stall_id_ex  = ctrl.stall_id_ex;
  assign stall_ex_mem = ctrl.stall_ex_mem;
  assign stall_mem_wb = ctrl.stall_mem_wb;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_ex  = ctrl.flush_id_ex;
  assign flush_ex_mem = ctrl.flush_ex_mem;
  assign flush_mem_wb = ctrl.flush_mem_wb;

endmodule
